// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_unit_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the control FSM and the mul/div unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_nxt
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // acc = {upper, lower}: product/multiplier for mult, remainder/quotient for div
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        diff    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        acc_nxt = acc;
        if (is_div) begin
            if (!diff[WIDTH])
                acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
        end else if (acc[0]) begin
            acc_nxt = {sum, acc[WIDTH-1:1]};
        end else begin
            acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO; owns the HI/LO registers.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_nxt, prod_fix;
    logic [WIDTH-1:0]   opnd, a_orig, hi_q, lo_q, res_hi, res_lo, a_mag, b_mag;
    logic               is_div, neg_res, neg_rem, dz, busy_q, done_q, sgn;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc     (acc),
        .opnd    (opnd),
        .acc_nxt (acc_nxt)
    );

    // Even op codes in the iterative group are the signed variants
    always_comb begin
        sgn   = ~bus.op[0];
        a_mag = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    always_comb begin
        prod_fix = neg_res ? -acc_nxt : acc_nxt;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (dz) begin
                res_hi = a_orig;
                res_lo = '1;
            end else begin
                res_lo = neg_res ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
                res_hi = neg_rem ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            a_orig  <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state   <= S_RUN;
                                busy_q  <= 1'b1;
                                cnt     <= '0;
                                is_div  <= bus.op[1];
                                neg_res <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                neg_rem <= sgn & bus.a[WIDTH-1];
                                dz      <= (bus.b == '0);
                                a_orig  <= bus.a;
                                opnd    <= b_mag;
                                acc     <= {{WIDTH{1'b0}}, a_mag};
                            end
                            OP_MTHI: hi_q <= bus.a;
                            OP_MTLO: lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'b000: begin q = sa * sb; p = q; end
            3'b001: p = {32'h0, a} * {32'h0, b};
            3'b010: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
            end
            3'b011: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
            default: p = 64'h0;
        endcase
        return p;
    endfunction

    // Issue an iterative op and wait for done; operands are scrambled after capture.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name, output int nbusy);
        logic [63:0] exp;
        bit          seen;
        exp = model(op, a, b);
        nbusy = 0;
        seen = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
        for (int i = 0; i < 80; i++) begin
            if (bus.done) begin seen = 1'b1; break; end
            if (bus.busy) nbusy++;
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: done never seen", name);
        end else if ({bus.hi, bus.lo} !== exp) begin
            errors++;
            $display("FAIL %s op=%0d a=%h b=%h: got hi=%h lo=%h want hi=%h lo=%h",
                     name, op, a, b, bus.hi, bus.lo, exp[63:32], exp[31:0]);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.hi !== 0 || bus.lo !== 0 || bus.busy !== 0 || bus.done !== 0) begin
            errors++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b want all 0", bus.hi, bus.lo, bus.busy, bus.done);
        end
    endtask

    task automatic test_multu_max();
        int nb;
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", nb);
        checks++;
        if (nb != 32) begin errors++; $display("FAIL busy_len: got %0d cycles want 32", nb); end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse: done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_directed();
        int nb;
        run_op(3'b000, 32'hFFFF_FFFD, 32'd7, "mult_neg", nb);
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, "div_neg", nb);
        run_op(3'b011, 32'd100, 32'd7, "divu", nb);
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", nb);
        run_op(3'b011, 32'h0000_1234, 32'h0, "divu_zero", nb);
        run_op(3'b010, 32'hFFFF_FF00, 32'h0, "div_zero", nb);
        run_op(3'b000, 32'h8000_0000, 32'h8000_0000, "mult_min", nb);
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] lo0;
        lo0 = bus.lo;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== lo0 || bus.busy !== 0 || bus.done !== 0) begin
            errors++;
            $display("FAIL mthi: hi=%h lo=%h busy=%b done=%b want hi=deadbeef lo=%h 0 0", bus.hi, bus.lo, bus.busy, bus.done, lo0);
        end
        bus.start = 1'b1; bus.op = 3'b101; bus.a = 32'h1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== 32'h1 || bus.busy !== 0 || bus.done !== 0) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b want deadbeef 1 0 0", bus.hi, bus.lo, bus.busy, bus.done);
        end
        bus.start = 1'b1; bus.op = 3'b110; bus.a = 32'h5555_5555; bus.b = 32'h3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== 32'h1 || bus.busy !== 0 || bus.done !== 0) begin
            errors++;
            $display("FAIL noop: hi=%h lo=%h busy=%b done=%b want deadbeef 1 0 0", bus.hi, bus.lo, bus.busy, bus.done);
        end
    endtask

    task automatic test_busy_ignore();
        logic [63:0] exp;
        bit seen;
        int extra;
        exp = model(3'b010, 32'hFFFF_FFF9, 32'd2);
        seen = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'hFFFF_FFF9; bus.b = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'h1234_5678; bus.b = 32'h9;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'hAAAA_AAAA;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen || {bus.hi, bus.lo} !== exp) begin
            errors++;
            $display("FAIL busy_ignore: seen=%b hi=%h lo=%h want hi=%h lo=%h", seen, bus.hi, bus.lo, exp[63:32], exp[31:0]);
        end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL busy_ignore_tail: %0d busy/done cycles want 0", extra); end
    endtask

    task automatic test_random();
        int nb;
        logic [2:0] op;
        logic [31:0] a, b;
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 20));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(op, a, b, "random", nb);
        end
    endtask

    task automatic test_reset_mid();
        int nb;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'h7; bus.b = 32'h9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.hi !== 0 || bus.lo !== 0 || bus.busy !== 0 || bus.done !== 0) begin
            errors++;
            $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b want all 0", bus.hi, bus.lo, bus.busy, bus.done);
        end
        @(negedge clk);
        reset = 1'b1;
        run_op(3'b001, 32'd3, 32'd5, "post_reset_multu", nb);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 3'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        test_multu_max();
        test_directed();
        test_mthi_mtlo();
        test_busy_ignore();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage of the multicycle processor.
- Consumes the two register-file read buses (rs → a, rt → b) and holds the HI/LO result registers.
- The control FSM issues an op and waits on busy/done before mfhi/mflo results are used or written back.
- Implements MULT, MULTU, DIV, DIVU, MTHI, MTLO.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  op request, sampled on rising clk.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
- a  in  WIDTH  rs operand (busA).
- b  in  WIDTH  rt operand (busB).
- busy  out  1  iteration in progress.
- done  out  1  one-cycle pulse when HI/LO is updated by mult/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, done=0, FSM to IDLE. Asserting reset mid-operation aborts it; HI/LO end at 0.
- FSM states:
  - IDLE: start && !busy with op MULT..DIVU latches |a|, |b| (magnitudes taken for signed ops), result sign, remainder sign and divide-by-zero flag, then goes to RUN with counter=0 and busy=1.
  - RUN: one shift-add (mult) or restoring shift-subtract (div) step per cycle. Counter increments each cycle. At counter==WIDTH-1 the edge applies sign fix-up, writes hi/lo, sets done=1, clears busy and returns to IDLE.
- Latency:
  - Start accepted at edge E0; busy=1 after E0.
  - hi/lo valid after edge E32 (WIDTH edges), with done=1 during the cycle following E32.
  - The next start can be accepted at E33.
- MTHI/MTLO complete in one cycle: with start in IDLE, hi<=a (MTHI) or lo<=a (MTLO) at that edge. No busy, no done.
- start while busy: ignored entirely, with no effect on operands or HI/LO.
- No-op codes: ignored.
- hi/lo hold their previous values throughout RUN; intermediate state lives only in internal accumulators.
- Multiply: 2*WIDTH-bit product, hi=upper, lo=lower. Signed: negate the unsigned product when sign(a) xor sign(b).
- Divide: lo=quotient, hi=remainder. Signed: quotient negated if signs differ; remainder takes the sign of a (truncating division).
- Boundary cases:
  - DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0. No trap.
  - Divide by zero (b==0, either signedness): still runs the full WIDTH cycles, then hi=a (original, unsigned-abs not applied), lo=all ones.
  - Operands are captured at E0; a/b changes during RUN have no effect.
- done is never asserted for MTHI/MTLO or ignored starts.

Decomposition:
- Shared package: op encodings (OP_MULT..OP_MTLO), FSM state encodings (S_IDLE, S_RUN), WIDTH default.
- One sub-module is natural: muldiv_step, a combinational single iteration (mult add-shift / div trial subtract).
- FSM, counter, sign handling and HI/LO registers stay in the top module.

Test Plan:
- MULTU a=0xFFFF_FFFF b=0xFFFF_FFFF → after 32 cycles done=1, hi=0xFFFF_FFFE, lo=0x0000_0001; busy high exactly 32 cycles.
- MULT a=0xFFFF_FFFD (-3) b=7 → hi=0xFFFF_FFFF, lo=0xFFFF_FFEB (-21).
- DIV a=-7 b=2 → lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1). DIVU a=100 b=7 → lo=14, hi=2.
- DIV a=0x8000_0000 b=0xFFFF_FFFF → lo=0x8000_0000, hi=0. DIVU a=0x1234 b=0 → hi=0x1234, lo=0xFFFF_FFFF.
- MTHI a=0xDEAD_BEEF then MTLO a=0x1 → hi/lo updated one edge after each start, busy/done stay 0. A MULT start issued while busy from a prior DIV → ignored, DIV result intact.
- Assert reset=0 at cycle 10 of a MULT → hi=lo=0, busy=done=0 immediately (asynchronous). After release, a new MULTU 3*5 gives lo=15.
